// File: rtl/memory_responder.sv
// rtl/memory_responder.sv - single-port word memory with fixed-latency request/response handshake; optional MEMORY_RESPONDER_MISALIGN_TRAP_EN
package Bundle;
    typedef enum logic [1:0] {M_X = 2'd0, M_XRD = 2'd1, M_XWR = 2'd2} mem_fcn_e;
    typedef enum logic [2:0] {MT_X = 3'd0, MT_B = 3'd1, MT_H = 3'd2, MT_W = 3'd3,
                              MT_BU = 3'd4, MT_HU = 3'd5} mem_typ_e;

    typedef struct packed {
        logic [31:0] addr;
        mem_fcn_e    fcn;
        mem_typ_e    typ;
        logic [31:0] data;
    } MemReq;

    typedef struct packed {
        logic  req_valid;
        MemReq req;
    } MemoryIn;

    typedef struct packed {
        logic [31:0] data;
    } MemResp;

    typedef struct packed {
        MemResp res;
    } MemoryOut;
endpackage

module memory_responder #(
    parameter int DEPTH_WORDS = 4096,
    parameter int WAIT_CYCLES = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  Bundle::MemoryIn  mem_in,
    output Bundle::MemoryOut mem_out,
    output logic             req_ready,
    output logic             res_valid
`ifdef MEMORY_RESPONDER_MISALIGN_TRAP_EN
    ,
    output logic             res_misaligned
`endif
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

    state_e          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [31:0]     pend_data_q;
    logic [31:0]     res_data_q;
    logic [31:0]     mem [DEPTH_WORDS];

    logic [AW-1:0]   idx;
    logic [1:0]      off;
    logic            accept;
    logic            is_store;
    logic            mis;
    logic            wr_en;
    logic [3:0]      be;
    logic [31:0]     wdata;
    logic [31:0]     rd_word;
    logic [31:0]     sh;
    logic [31:0]     ext;
    logic [31:0]     resp_data;

    // Address bits above the array size alias and are deliberately ignored.
    logic unused_addr;
    assign unused_addr = &{1'b0, mem_in.req.addr[31:AW+2]};

    assign idx       = mem_in.req.addr[AW+1:2];
    assign req_ready = (state_q == IDLE) || (state_q == RESP);
    assign res_valid = (state_q == RESP);
    assign accept    = rst_n && mem_in.req_valid && req_ready;
    assign is_store  = (mem_in.req.fcn == Bundle::M_XWR);
    assign wr_en     = accept && is_store && !mis;
    assign rd_word   = mem[idx];
    assign sh        = rd_word >> {off, 3'b000};
    assign resp_data = (is_store || mis) ? 32'h0 : ext;
    assign mem_out.res.data = res_data_q;

`ifdef MEMORY_RESPONDER_MISALIGN_TRAP_EN
    assign mis = (((mem_in.req.typ == Bundle::MT_H) || (mem_in.req.typ == Bundle::MT_HU)) && mem_in.req.addr[0])
              || ((mem_in.req.typ == Bundle::MT_W) && (mem_in.req.addr[1:0] != 2'b00));
`else
    assign mis = 1'b0;
`endif

    // Lane offset, byte enables, replicated write data and load extraction; low bits forced to natural alignment.
    always_comb begin
        off   = 2'b00;
        be    = 4'b0000;
        wdata = mem_in.req.data;
        ext   = rd_word;
        case (mem_in.req.typ)
            Bundle::MT_W: begin
                be = 4'b1111;
            end
            Bundle::MT_H, Bundle::MT_HU: begin
                off   = {mem_in.req.addr[1], 1'b0};
                be    = mem_in.req.addr[1] ? 4'b1100 : 4'b0011;
                wdata = {2{mem_in.req.data[15:0]}};
                ext   = (mem_in.req.typ == Bundle::MT_H) ? {{16{sh[15]}}, sh[15:0]} : {16'h0, sh[15:0]};
            end
            Bundle::MT_B, Bundle::MT_BU: begin
                off   = mem_in.req.addr[1:0];
                be    = 4'b0001 << mem_in.req.addr[1:0];
                wdata = {4{mem_in.req.data[7:0]}};
                ext   = (mem_in.req.typ == Bundle::MT_B) ? {{24{sh[7]}}, sh[7:0]} : {24'h0, sh[7:0]};
            end
            default: begin
                be = 4'b0000;
            end
        endcase
    end

    // Array write commits on the acceptance edge; contents are never reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem[idx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    // Next-state logic: accept in IDLE/RESP, count down in WAIT, respond for one cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE, RESP: begin
                state_d = IDLE;
                if (accept) begin
                    if (WAIT_CYCLES == 0) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = WAIT_INIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counter and response registers; load data is captured at acceptance so later stores cannot disturb it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            pend_data_q <= 32'h0;
            res_data_q  <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                pend_data_q <= resp_data;
            end
            if (state_d == RESP) begin
                res_data_q <= (state_q == WAIT) ? pend_data_q : resp_data;
            end
        end
    end

`ifdef MEMORY_RESPONDER_MISALIGN_TRAP_EN
    logic pend_mis_q;

    // Misalignment flag follows the same capture path as the response data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend_mis_q     <= 1'b0;
            res_misaligned <= 1'b0;
        end else begin
            if (accept) begin
                pend_mis_q <= mis;
            end
            if (state_d == RESP) begin
                res_misaligned <= (state_q == WAIT) ? pend_mis_q : mis;
            end
        end
    end
`endif

endmodule
